// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, port owner and latency counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_EXT
    } owner_t;

    // Read latency counter width; supports RD_LAT up to 256.
    localparam int LAT_W = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the core port, the external loader port and the memory macro.
// slave is the arbiter's view, master is the requester/memory side view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_stall;

    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic [DW-1:0] ext_rdata;
    logic          ext_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_rdata, ext_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_rdata, ext_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of cycles the external port has waited; ge_lim forces the next grant to ext.
module arb_starve_ctr #(
    parameter int STARVE_LIM = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic ge_lim
);
    localparam int CW = $clog2(STARVE_LIM + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: combinational blocks assign a default first so no path leaves cnt_d unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < CW'(STARVE_LIM))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ge_lim = (cnt_q >= CW'(STARVE_LIM));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core and the external loader onto the single memory port: IDLE -> ISSUE -> [WAIT] -> ACK.
// Define ARB_STATS_EN to add grant and starvation-hit counters as extra outputs.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]          cpu_grant_cnt,
    output logic [15:0]          ext_grant_cnt,
    output logic [15:0]          starve_hit_cnt
`endif
);
    arb_state_t     state_q;
    owner_t         owner_q;
    logic           we_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;
    logic [LAT_W-1:0] lat_q;
    logic           mem_en_q;
    logic           cpu_ack_q, ext_ack_q;
    logic [DW-1:0]  cpu_rdata_q, ext_rdata_q;

    logic ext_ge_lim;
    logic grant, ext_win, ext_grant, ext_busy;

    assign grant     = (state_q == IDLE) && (bus.cpu_req || bus.ext_req);
    assign ext_win   = bus.ext_req && (!bus.cpu_req || ext_ge_lim);
    assign ext_grant = grant && ext_win;
    assign ext_busy  = (state_q != IDLE) && (owner_q == OWN_EXT);

    arb_starve_ctr #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (bus.ext_req && !ext_busy && !ext_grant),
        .clr    (ext_grant),
        .ge_lim (ext_ge_lim)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: datapath registers are reset too because rdata and mem_* must read 0 out of reset.
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_q       <= '0;
            mem_en_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ext_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            mem_en_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            ext_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        owner_q  <= ext_win ? OWN_EXT : OWN_CPU;
                        we_q     <= ext_win ? bus.ext_we    : bus.cpu_we;
                        addr_q   <= ext_win ? bus.ext_addr  : bus.cpu_addr;
                        wdata_q  <= ext_win ? bus.ext_wdata : bus.cpu_wdata;
                        mem_en_q <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        cpu_ack_q <= (owner_q == OWN_CPU);
                        ext_ack_q <= (owner_q == OWN_EXT);
                        state_q   <= ACK;
                    end else begin
                        lat_q   <= LAT_W'(RD_LAT - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_q == '0) begin
                        if (owner_q == OWN_EXT) ext_rdata_q <= bus.mem_rdata;
                        else                    cpu_rdata_q <= bus.mem_rdata;
                        cpu_ack_q <= (owner_q == OWN_CPU);
                        ext_ack_q <= (owner_q == OWN_EXT);
                        state_q   <= ACK;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                ACK: begin
                    // A request still high here is left for the next IDLE arbitration.
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_stall = bus.cpu_req && !cpu_ack_q;
    assign bus.ext_ack   = ext_ack_q;
    assign bus.ext_rdata = ext_rdata_q;

`ifdef ARB_STATS_EN
    logic [15:0] cpu_grant_q, ext_grant_q, starve_hit_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_grant_q  <= '0;
            ext_grant_q  <= '0;
            starve_hit_q <= '0;
        end else begin
            if (grant && !ext_win)          cpu_grant_q  <= cpu_grant_q + 16'd1;
            if (ext_grant)                  ext_grant_q  <= ext_grant_q + 16'd1;
            if (ext_grant && bus.cpu_req)   starve_hit_q <= starve_hit_q + 16'd1;
        end
    end

    assign cpu_grant_cnt  = cpu_grant_q;
    assign ext_grant_cnt  = ext_grant_q;
    assign starve_hit_cnt = starve_hit_q;
`endif

endmodule
